// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder
//   Two-stage pipelined carry-select adder/subtractor with a valid/ready
//   handshake. Stage 1 adds each BLK-bit block for both possible carry-ins.
//   Stage 2 picks the right block results through a mux chain that is
//   driven by the real block carries, then registers sum, c_out and ovf.
//
//   Optional build macro: CSEL_ADD_SAT_EN
//     When defined, an overflowing result is clamped to the most positive
//     or most negative value. ovf and c_out are reported unchanged.
//     When undefined, the result always wraps modulo 2^WIDTH.

module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;

    // Reject geometries where the blocks do not tile the word, or where
    // there is no upper block for the carry-select mux chain to work on.
    generate
        if (((WIDTH % BLK) != 0) || (WIDTH < 2 * BLK)) begin : gParamCheck
            $error("pipelined_csel_adder: WIDTH (%0d) must be a multiple of BLK (%0d) and at least 2*BLK",
                   WIDTH, BLK);
        end
    endgenerate

    // Operand preparation
    logic [WIDTH-1:0] bEff;
    logic             cinEff;

    // Stage 1 next-state and registers
    logic [BLK:0]                 blk0Res;
    logic [BLK:0]                 blkRes0;
    logic [BLK:0]                 blkRes1;
    logic [BLK-1:0]               blk0Sum_d,   blk0Sum_q;
    logic                         blk0Carry_d, blk0Carry_q;
    logic [NBLK-1:1][BLK-1:0]     sum0_d,      sum0_q;
    logic [NBLK-1:1][BLK-1:0]     sum1_d,      sum1_q;
    logic [NBLK-1:1]              carry0_d,    carry0_q;
    logic [NBLK-1:1]              carry1_d,    carry1_q;
    logic                         aMsb_d,      aMsb_q;
    logic                         bMsb_d,      bMsb_q;
    logic                         s1Valid_q;

    // Stage 2 next-state and registers
    logic [WIDTH-1:0]             sumRes;
    logic                         selCarry;
    logic [WIDTH-1:0]             sum_d,       sum_q;
    logic                         cOut_d,      cOut_q;
    logic                         ovf_d,       ovf_q;
    logic                         s2Valid_q;

    // Pipeline advance controls
    logic                         s1Load;
    logic                         s2Load;

    // Subtraction is A + ~B + 1, so invert B and force the carry-in;
    // the caller's c_in is ignored while subtracting.
    always_comb begin
        bEff   = sub ? ~b : b;
        cinEff = sub ? 1'b1 : c_in;
    end

    // Block 0 ripples with the true carry-in; every upper block is summed
    // twice, once assuming carry-in 0 and once assuming carry-in 1.
    always_comb begin
        blk0Res     = '0;
        blkRes0     = '0;
        blkRes1     = '0;
        sum0_d      = '0;
        sum1_d      = '0;
        carry0_d    = '0;
        carry1_d    = '0;

        blk0Res     = {1'b0, a[BLK-1:0]} + {1'b0, bEff[BLK-1:0]} + {{BLK{1'b0}}, cinEff};
        blk0Sum_d   = blk0Res[BLK-1:0];
        blk0Carry_d = blk0Res[BLK];

        for (int k = 1; k < NBLK; k++) begin
            blkRes0     = {1'b0, a[k*BLK +: BLK]} + {1'b0, bEff[k*BLK +: BLK]};
            blkRes1     = {1'b0, a[k*BLK +: BLK]} + {1'b0, bEff[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
            sum0_d[k]   = blkRes0[BLK-1:0];
            carry0_d[k] = blkRes0[BLK];
            sum1_d[k]   = blkRes1[BLK-1:0];
            carry1_d[k] = blkRes1[BLK];
        end

        aMsb_d = a[WIDTH-1];
        bMsb_d = bEff[WIDTH-1];
    end

    // Stage 2 may take a beat when it is empty or its beat is leaving;
    // stage 1 may take one when it is empty or its beat moves to stage 2.
    // Neither term looks at in_valid, so in_ready never loops back on it.
    assign s2Load   = !s2Valid_q || out_ready;
    assign s1Load   = !s1Valid_q || s2Load;
    assign in_ready = s1Load;

    // Stage 1 register: capture the precomputed block pairs on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            blk0Sum_q   <= '0;
            blk0Carry_q <= 1'b0;
            sum0_q      <= '0;
            sum1_q      <= '0;
            carry0_q    <= '0;
            carry1_q    <= '0;
            aMsb_q      <= 1'b0;
            bMsb_q      <= 1'b0;
        end else if (s1Load) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                blk0Sum_q   <= blk0Sum_d;
                blk0Carry_q <= blk0Carry_d;
                sum0_q      <= sum0_d;
                sum1_q      <= sum1_d;
                carry0_q    <= carry0_d;
                carry1_q    <= carry1_d;
                aMsb_q      <= aMsb_d;
                bMsb_q      <= bMsb_d;
            end
        end
    end

    // Carry-select resolution: each block's real carry-in picks which of the
    // two precomputed pairs is correct, and that pair's carry feeds the next.
    always_comb begin
        sumRes            = '0;
        selCarry          = blk0Carry_q;
        sumRes[BLK-1:0]   = blk0Sum_q;

        for (int k = 1; k < NBLK; k++) begin
            if (selCarry) begin
                sumRes[k*BLK +: BLK] = sum1_q[k];
                selCarry             = carry1_q[k];
            end else begin
                sumRes[k*BLK +: BLK] = sum0_q[k];
                selCarry             = carry0_q[k];
            end
        end

        cOut_d = selCarry;
        ovf_d  = (aMsb_q == bMsb_q) && (sumRes[WIDTH-1] != aMsb_q);
        sum_d  = sumRes;

`ifdef CSEL_ADD_SAT_EN
        if (ovf_d) begin
            sum_d = aMsb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage 2 register: outputs only change when a new beat moves in, so a
    // stalled result stays stable until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            sum_q     <= '0;
            cOut_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (s2Load) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                sum_q  <= sum_d;
                cOut_q <= cOut_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = s2Valid_q;
    assign sum       = sum_q;
    assign c_out     = cOut_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder
//   Directed bench for pipelined_csel_adder at WIDTH=16, BLK=4. Inputs change
//   1 time unit after a rising edge; outputs are compared in the same
//   window, well away from the next edge. Saturated expectations follow
//   CSEL_ADD_SAT_EN when the bench is built with it.

module tb_pipelined_csel_adder;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;

`ifdef CSEL_ADD_SAT_EN
    localparam logic [15:0] POS_OVF_SUM = 16'h7FFF;
    localparam logic [15:0] NEG_OVF_SUM = 16'h8000;
`else
    localparam logic [15:0] POS_OVF_SUM = 16'h8000;
    localparam logic [15:0] NEG_OVF_SUM = 16'h7FFF;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int checks;
    int passes;

    pipelined_csel_adder #(
        .WIDTH (WIDTH),
        .BLK   (BLK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv);
        in_valid = v;
        a        = av;
        b        = bv;
        c_in     = cv;
        sub      = sv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passes++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One isolated beat: present it for a single cycle, confirm nothing is
    // out after one edge, then check the full result after the second edge.
    task automatic runBeat(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv, input logic sv, input logic [15:0] expSum,
                           input logic expCout, input logic expOvf);
        applyStimulus(1'b1, av, bv, cv, sv);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_sum"},   {16'b0, sum},       {16'b0, expSum});
        checkOutput({tag, "_cout"},  {31'b0, c_out},     {31'b0, expCout});
        checkOutput({tag, "_ovf"},   {31'b0, ovf},       {31'b0, expOvf});
        tick();
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_sum",   {16'b0, sum},       32'd0);
        checkOutput("rst_cout",  {31'b0, c_out},     32'd0);
        checkOutput("rst_ovf",   {31'b0, ovf},       32'd0);
        checkOutput("rst_ready", {31'b0, in_ready},  32'd1);

        $display("[TB] directed arithmetic beats");
        runBeat("carry_blk1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        runBeat("full_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        runBeat("no_carry",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        runBeat("carry_blk3", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        runBeat("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runBeat("sub_nobrw",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        runBeat("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF_SUM, 1'b0, 1'b1);
        runBeat("ovf_neg",    16'h8000, 16'hFFFF, 1'b0, 1'b0, NEG_OVF_SUM, 1'b1, 1'b1);
        runBeat("ovf_subneg", 16'h8000, 16'h0001, 1'b0, 1'b1, NEG_OVF_SUM, 1'b1, 1'b1);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        checkOutput("bp_ready0", {31'b0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0);
        checkOutput("bp_ready1", {31'b0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0);
        checkOutput("bp_ready2", {31'b0, in_ready},  32'd0);
        checkOutput("bp_valid2", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_sum2",   {16'b0, sum},       32'h0002);
        tick();
        checkOutput("bp_ready3", {31'b0, in_ready},  32'd0);
        checkOutput("bp_sum3",   {16'b0, sum},       32'h0002);
        tick();
        checkOutput("bp_sum4",   {16'b0, sum},       32'h0002);
        checkOutput("bp_valid4", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_rel", {31'b0, in_ready}, 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput("bp_valid_b2", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_sum_b2",   {16'b0, sum},       32'h0004);
        tick();
        checkOutput("bp_valid_b3", {31'b0, out_valid}, 32'd1);
        checkOutput("bp_sum_b3",   {16'b0, sum},       32'h0006);
        tick();
        checkOutput("bp_drained",  {31'b0, out_valid}, 32'd0);

        $display("[TB] reset mid-flight");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        checkOutput("mr_pre_sum", {16'b0, sum}, 32'h0033);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mr_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mr_sum",   {16'b0, sum},       32'd0);
        checkOutput("mr_cout",  {31'b0, c_out},     32'd0);
        checkOutput("mr_ovf",   {31'b0, ovf},       32'd0);
        checkOutput("mr_ready", {31'b0, in_ready},  32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("mr_quiet1", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("mr_quiet2", {31'b0, out_valid}, 32'd0);
        runBeat("mr_next", 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
- Parametrised, two-stage pipelined carry-select adder/subtractor with a valid/ready handshake.
- Operands are split into BLK-bit blocks. Stage 1 precomputes each upper block's sum for carry-in 0 and carry-in 1. Stage 2 resolves the block carry chain through muxes.
- Serves as the general arithmetic datapath element, replacing fixed-width combinational adders, wherever timing requires a registered result.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of BLK, minimum 2*BLK.
- BLK, 4, carry-select block width in bits; block 0 is a plain ripple block.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = A+B+c_in, 1 = A-B (A + ~B + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry-out of MSB; for sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Fixed for this block: one clock; reset is synchronous and active-high.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Operand preparation (combinational, before stage 1):
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in.
- Stage 1 registers:
  - Block 0 sum and carry, computed from cin_eff.
  - For each block k >= 1: the (sum, carry) pair for carry-in 0 and the pair for carry-in 1.
  - MSB operand signs a[W-1] and b_eff[W-1], for overflow.
  - s1_valid.
- Stage 2 (mux chain and registers):
  - Block k selects its carry-in-1 pair if the carry from block k-1 is 1, otherwise its carry-in-0 pair.
  - The selected carries chain combinationally from block 1 up to block WIDTH/BLK-1.
  - sum, c_out and ovf are registered; out_valid = s2_valid.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb).
- Latency: exactly 2 cycles from an input transfer to out_valid, when not stalled.
- Throughput: one result per cycle while out_ready=1.
- Stall and advance rules:
  - Stage 2 may load when !s2_valid || out_ready.
  - Stage 1 may load when !s1_valid || stage 2 loads this cycle.
  - in_ready = stage-1 may load. in_ready must not depend combinationally on in_valid.
- Stall behaviour: while out_valid && !out_ready, sum, c_out and ovf hold stable; at most 2 beats are buffered.
- Ordering: results emerge strictly in acceptance order; no beat is dropped or duplicated.
- Simultaneous input and output transfer with both stages full: the pipeline shifts and stays full.
- Reset values:
  - out_valid = 0, sum = 0, c_out = 0, ovf = 0.
  - s1_valid = s2_valid = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted for them after reset.
- Wrap-around: the result is modulo 2^WIDTH; the carry leaves only through c_out.
- Elaboration error: an $error is raised if WIDTH % BLK != 0 or WIDTH < 2*BLK.

Optional Feature:
- Macro: CSEL_ADD_SAT_EN.
- When defined, on ovf=1 sum is clamped at stage 2:
  - Positive overflow (a_msb=0) gives {1'b0,{WIDTH-1{1'b1}}}.
  - Negative overflow gives {1'b1,{WIDTH-1{1'b0}}}.
  - ovf and c_out are still reported unchanged.
- When undefined, sum always wraps. Latency and handshake are identical in both builds.

Test Plan:
- Carry into block 1 (WIDTH=16, BLK=4): a=0x00FF, b=0x0001, c_in=0, sub=0 -> 2 cycles later out_valid=1, sum=0x0100, c_out=0, ovf=0.
- Full carry chain: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1, ovf=0; then a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, c_in=1 (ignored) -> sum=0xFFFE, c_out=0, ovf=0. Subtract without borrow: a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
- Overflow: a=0x7FFF, b=0x0001 -> ovf=1, sum=0x8000 without the macro, sum=0x7FFF with CSEL_ADD_SAT_EN. Also a=0x8000, b=0xFFFF -> ovf=1, sum=0x7FFF without the macro, 0x8000 with it.
- Backpressure: out_ready=0, present 3 back-to-back beats (1+1, 2+2, 3+3) -> in_ready=0 after 2 accepted; sum holds 0x0002 stable. Then out_ready=1 -> outputs 0x0002, 0x0004, 0x0006 in order on consecutive cycles.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle before the first emits -> out_valid stays 0 and all outputs are 0. The next beat, 0x0010+0x0020, emits 0x0030 with 2-cycle latency.
